// File: rtl/audio_pkg.sv
// Shared audio-capture types and default timing constants for the PDM
// microphone front end.
package audio_pkg;

  localparam int PDM_COUNT_PERIOD = 32;
  localparam int NUM_PDM_SAMPLES  = 256;
  localparam int SETTLE_WINDOWS   = 1;

  typedef logic [1:0] mic_id_t;
  localparam mic_id_t MIC_NONE = 2'd3;

  typedef enum logic {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } cap_state_t;

  // Ones tally clipped to the 8-bit sample range (a full window of ones reads 255).
  function automatic logic [7:0] sat_u8(input logic [15:0] v);
    return (v > 16'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/pdm_capture_scheduler_if.sv
// Capture-path signal bundle between the mic pins / playback path and the
// PDM capture scheduler.
interface pdm_capture_scheduler_if;
  import audio_pkg::*;

  logic       enable_in;
  mic_id_t    mic_sel_in;
  logic [2:0] mic_data_in;
  logic       mic_clk_out;
  logic [7:0] sample_out;
  logic       sample_valid_out;
  mic_id_t    active_mic_out;
  logic       settling_out;

  modport slave (
    input  enable_in, mic_sel_in, mic_data_in,
    output mic_clk_out, sample_out, sample_valid_out, active_mic_out, settling_out
  );

  modport master (
    output enable_in, mic_sel_in, mic_data_in,
    input  mic_clk_out, sample_out, sample_valid_out, active_mic_out, settling_out
  );
endinterface

// File: rtl/pdm_clk_gen.sv
// Mic clock divider: square wave of PDM_COUNT_PERIOD clk_in cycles plus a
// one-cycle strobe on the cycle the mic clock first reads high.
module pdm_clk_gen #(
  parameter int PDM_COUNT_PERIOD = 32
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic enable_in,
  output logic mic_clk_out,
  output logic pdm_step_out
);

  localparam int CW = (PDM_COUNT_PERIOD > 2) ? $clog2(PDM_COUNT_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PDM_COUNT_PERIOD - 1);
  localparam logic [CW-1:0] HALF = CW'(PDM_COUNT_PERIOD / 2);

  logic [CW-1:0] count_reg, count_next;
  logic          mic_clk_reg, step_reg;

  // Disabled divider parks at 0 so re-enable restarts the period cleanly.
  always_comb begin
    count_next = '0;
    if (enable_in && (count_reg != LAST)) begin
      count_next = count_reg + CW'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_reg   <= '0;
      mic_clk_reg <= 1'b0;
      step_reg    <= 1'b0;
    end else begin
      count_reg   <= count_next;
      mic_clk_reg <= (count_next >= HALF);
      step_reg    <= (count_next == HALF);
    end
  end

  assign mic_clk_out  = mic_clk_reg;
  assign pdm_step_out = step_reg;

endmodule

// File: rtl/pdm_capture_scheduler.sv
// Three-mic PDM capture: one mic tallied per window, switches deferred to
// window boundaries and followed by SETTLE windows whose samples are dropped.
module pdm_capture_scheduler #(
  parameter int PDM_COUNT_PERIOD = audio_pkg::PDM_COUNT_PERIOD,
  parameter int NUM_PDM_SAMPLES  = audio_pkg::NUM_PDM_SAMPLES,
  parameter int SETTLE_WINDOWS   = audio_pkg::SETTLE_WINDOWS
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  pdm_capture_scheduler_if.slave  cap
);
  import audio_pkg::*;

  localparam int BW = $clog2(NUM_PDM_SAMPLES);
  localparam int TW = BW + 1;
  localparam int SW = $clog2(SETTLE_WINDOWS + 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(NUM_PDM_SAMPLES - 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_WINDOWS);

  logic          pdm_step;
  logic [2:0]    mic_hit;
  logic          mic_bit;
  logic          window_end;
  logic [TW-1:0] tally_sum;

  cap_state_t    state_reg, state_next;
  logic [SW-1:0] settle_reg, settle_next;
  mic_id_t       active_reg, active_next;
  mic_id_t       pending_reg, pending_next;
  logic          pend_flag_reg, pend_flag_next;
  logic [BW-1:0] bit_cnt_reg, bit_cnt_next;
  logic [TW-1:0] tally_reg, tally_next;
  logic [7:0]    sample_reg, sample_next;
  logic          valid_reg, valid_next;
  logic          settling_reg, settling_next;

  pdm_clk_gen #(
    .PDM_COUNT_PERIOD(PDM_COUNT_PERIOD)
  ) u_clk_gen (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .enable_in   (cap.enable_in),
    .mic_clk_out (cap.mic_clk_out),
    .pdm_step_out(pdm_step)
  );

  for (genvar gi = 0; gi < 3; gi++) begin : g_mic_sel
    assign mic_hit[gi] = cap.mic_data_in[gi] & (active_reg == 2'(gi));
  end
  assign mic_bit   = |mic_hit;
  assign tally_sum = tally_reg + TW'(mic_bit);

  // Decimation datapath; the closing step's bit is part of its own window.
  always_comb begin
    window_end   = 1'b0;
    bit_cnt_next = bit_cnt_reg;
    tally_next   = tally_reg;
    sample_next  = sample_reg;
    if (!cap.enable_in) begin
      bit_cnt_next = '0;
      tally_next   = '0;
    end else if (pdm_step) begin
      if (bit_cnt_reg == LAST_BIT) begin
        window_end   = 1'b1;
        bit_cnt_next = '0;
        tally_next   = '0;
        sample_next  = sat_u8(16'(tally_sum));
      end else begin
        bit_cnt_next = bit_cnt_reg + BW'(1);
        tally_next   = tally_sum;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg     <= SETTLE;
      settle_reg    <= SETTLE_LOAD;
      active_reg    <= '0;
      pending_reg   <= '0;
      pend_flag_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      settle_reg    <= settle_next;
      active_reg    <= active_next;
      pending_reg   <= pending_next;
      pend_flag_reg <= pend_flag_next;
    end
  end

  // A pending switch outranks the settle countdown at a boundary.
  always_comb begin
    state_next     = state_reg;
    settle_next    = settle_reg;
    active_next    = active_reg;
    pending_next   = pending_reg;
    pend_flag_next = 1'b0;
    if ((cap.mic_sel_in != MIC_NONE) && (cap.mic_sel_in != active_reg)) begin
      pending_next   = cap.mic_sel_in;
      pend_flag_next = 1'b1;
    end
    if (!cap.enable_in) begin
      state_next  = SETTLE;
      settle_next = SETTLE_LOAD;
    end else if (window_end) begin
      if (pend_flag_reg) begin
        active_next    = pending_reg;
        pend_flag_next = 1'b0;
        state_next     = SETTLE;
        settle_next    = SETTLE_LOAD;
      end else if (state_reg == SETTLE) begin
        settle_next = settle_reg - SW'(1);
        if (settle_reg == SW'(1)) begin
          state_next = RUN;
        end
      end
    end
  end

  always_comb begin
    valid_next    = window_end && (state_reg == RUN);
    settling_next = (state_next == SETTLE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bit_cnt_reg  <= '0;
      tally_reg    <= '0;
      sample_reg   <= '0;
      valid_reg    <= 1'b0;
      settling_reg <= 1'b0;
    end else begin
      bit_cnt_reg  <= bit_cnt_next;
      tally_reg    <= tally_next;
      sample_reg   <= sample_next;
      valid_reg    <= valid_next;
      settling_reg <= settling_next;
    end
  end

  assign cap.sample_out       = sample_reg;
  assign cap.sample_valid_out = valid_reg;
  assign cap.active_mic_out   = active_reg;
  assign cap.settling_out     = settling_reg;

endmodule

// File: tb/tb_pdm_capture_scheduler.sv
// Bench for pdm_capture_scheduler: default-parameter checkpoint table plus a
// small-parameter instance under random stimulus against a window-level model.
module tb_pdm_capture_scheduler;

  localparam int BP = 4;
  localparam int BN = 256;
  localparam int BS = 2;
  localparam int NA = 15;
  localparam int NB = 40000;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
    logic       exp_valid;
    logic [7:0] exp_sample;
    logic [1:0] exp_active;
    logic       exp_settling;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  pdm_capture_scheduler_if ifa ();
  pdm_capture_scheduler_if ifb ();

  pdm_capture_scheduler dut_a (.clk_in(clk), .rst_in(rst_a), .cap(ifa));
  pdm_capture_scheduler #(
    .PDM_COUNT_PERIOD(BP), .NUM_PDM_SAMPLES(BN), .SETTLE_WINDOWS(BS)
  ) dut_b (.clk_in(clk), .rst_in(rst_b), .cap(ifb));

  int vectors = 0;
  int miscompares = 0;
  vec_t tab [NA];

  int cyc_a = 0;
  bit a_live = 1'b0;
  int strobe_q [$];

  // Small-instance reference model state
  int         b_t;
  int         b_bits [$];
  int         b_settle;
  logic [1:0] b_active, b_pend;
  bit         b_pv;
  logic       m_clk, m_valid, m_settle;
  logic [7:0] m_sample;
  logic       en_d;
  logic [1:0] sel_d;
  logic [2:0] data_d;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (a_live && ifa.sample_valid_out === 1'b1) strobe_q.push_back(cyc_a);
  end

  task automatic run_a();
    int clk_err;
    int exp_strobe [3];
    exp_strobe = '{16369, 24561, 40945};
    clk_err = 0;
    ifa.enable_in = 1'b1;
    ifa.mic_sel_in = 2'd0;
    ifa.mic_data_in = 3'b011;
    repeat (3) @(posedge clk);
    #2;
    chk("a_reset_state", {ifa.mic_clk_out, ifa.sample_valid_out, ifa.sample_out,
                          ifa.active_mic_out, ifa.settling_out}, 32'd0);
    @(posedge clk);
    #1 rst_a = 1'b0;
    a_live = 1'b1;
    for (int r = 0; r < NA; r++) begin
      while (cyc_a < tab[r].cyc) begin
        @(posedge clk);
        cyc_a++;
        #1;
        ifa.mic_data_in = {1'b0, ~cyc_a[5], 1'b1};
        if (cyc_a == tab[r].cyc) ifa.mic_sel_in = tab[r].sel;
        #1;
        if (ifa.mic_clk_out !== ((cyc_a % 32) >= 16)) clk_err++;
      end
      chk($sformatf("a_valid@%0d", tab[r].cyc), ifa.sample_valid_out, tab[r].exp_valid);
      chk($sformatf("a_active@%0d", tab[r].cyc), ifa.active_mic_out, tab[r].exp_active);
      chk($sformatf("a_settling@%0d", tab[r].cyc), ifa.settling_out, tab[r].exp_settling);
      if (tab[r].exp_valid)
        chk($sformatf("a_sample@%0d", tab[r].cyc), ifa.sample_out, tab[r].exp_sample);
    end
    chk("a_mic_clk_wave_errors", clk_err, 0);
    chk("a_strobe_count", strobe_q.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("a_strobe_cycle[%0d]", i),
          (i < strobe_q.size()) ? strobe_q[i] : -1, exp_strobe[i]);
    // Reset asserted between edges must clear the outputs at once
    @(posedge clk);
    #3 rst_a = 1'b1;
    a_live = 1'b0;
    #1;
    chk("a_async_reset", {ifa.mic_clk_out, ifa.sample_valid_out, ifa.sample_out,
                          ifa.active_mic_out, ifa.settling_out}, 32'd0);
  endtask

  task automatic b_reset();
    b_t = 0;
    b_bits.delete();
    b_settle = BS;
    b_active = 2'd0;
    b_pend = 2'd0;
    b_pv = 1'b0;
    m_clk = 1'b0;
    m_valid = 1'b0;
    m_sample = 8'd0;
    m_settle = 1'b0;
  endtask

  // One clock edge of the spec rules, applied to the inputs of the cycle before it
  task automatic b_edge();
    bit         step, pv_n;
    logic [1:0] pend_n;
    int         sum;
    m_valid = 1'b0;
    step = ((b_t % BP) == BP / 2);
    pv_n = (sel_d != 2'd3) && (sel_d != b_active);
    pend_n = pv_n ? sel_d : b_pend;
    if (!en_d) begin
      b_t = 0;
      b_bits.delete();
      b_settle = BS;
    end else begin
      if (step) begin
        b_bits.push_back(int'(data_d[b_active]));
        if (b_bits.size() == BN) begin
          sum = b_bits.sum();
          m_sample = (sum > 255) ? 8'd255 : 8'(sum);
          b_bits.delete();
          m_valid = (b_settle == 0);
          if (b_pv) begin
            b_active = b_pend;
            pv_n = 1'b0;
            b_settle = BS;
          end else if (b_settle > 0) begin
            b_settle--;
          end
        end
      end
      b_t++;
    end
    b_pv = pv_n;
    b_pend = pend_n;
    m_clk = ((b_t % BP) >= BP / 2);
    m_settle = (b_settle > 0);
  endtask

  task automatic run_b();
    int dens [3];
    int en_hold, rst_hold, base;
    dens = '{256, 128, 200};
    en_hold = 0;
    rst_hold = 0;
    base = miscompares;
    ifb.enable_in = 1'b1;
    ifb.mic_sel_in = 2'd0;
    ifb.mic_data_in = 3'b001;
    b_reset();
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b0;
    en_d = ifb.enable_in;
    sel_d = ifb.mic_sel_in;
    data_d = ifb.mic_data_in;
    for (int n = 1; n <= NB; n++) begin
      @(posedge clk);
      if (!rst_b) b_edge();
      #1;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_b = 1'b0;
      end else if (n == 9000 || $urandom_range(0, 19999) == 0) begin
        rst_b = 1'b1;
        b_reset();
        rst_hold = $urandom_range(1, 4);
      end
      if (en_hold > 0) begin
        en_hold--;
        ifb.enable_in = (en_hold == 0);
      end else if (n == 1500 || $urandom_range(0, 5999) == 0) begin
        en_hold = (n == 1500) ? 300 : $urandom_range(1, 400);
        ifb.enable_in = 1'b0;
      end
      if (n == 6000) ifb.mic_sel_in = 2'd1;
      else if (n == 12000) ifb.mic_sel_in = 2'd3;
      else if (n == 14000) ifb.mic_sel_in = 2'd2;
      else if (n == 14300) ifb.mic_sel_in = 2'd0;
      else if ($urandom_range(0, 1499) == 0) ifb.mic_sel_in = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 999) == 0)
        for (int k = 0; k < 3; k++) dens[k] = $urandom_range(0, 256);
      for (int k = 0; k < 3; k++)
        ifb.mic_data_in[k] = ($urandom_range(0, 255) < dens[k]);
      en_d = ifb.enable_in;
      sel_d = ifb.mic_sel_in;
      data_d = ifb.mic_data_in;
      #1;
      chk($sformatf("b_ctrl@%0d", n),
          {ifb.mic_clk_out, ifb.sample_valid_out, ifb.active_mic_out, ifb.settling_out},
          {m_clk, m_valid, b_active, m_settle});
      if (m_valid) chk($sformatf("b_sample@%0d", n), ifb.sample_out, m_sample);
      if (miscompares - base >= 10) break;
    end
  endtask

  initial begin
    tab[0]  = '{1,     2'd0, 1'b0, 8'd0,   2'd0, 1'b1};
    tab[1]  = '{8176,  2'd0, 1'b0, 8'd0,   2'd0, 1'b1};
    tab[2]  = '{8177,  2'd0, 1'b0, 8'd0,   2'd0, 1'b0};
    tab[3]  = '{9000,  2'd2, 1'b0, 8'd0,   2'd0, 1'b0};
    tab[4]  = '{9500,  2'd0, 1'b0, 8'd0,   2'd0, 1'b0};
    tab[5]  = '{10000, 2'd3, 1'b0, 8'd0,   2'd0, 1'b0};
    tab[6]  = '{16368, 2'd3, 1'b0, 8'd0,   2'd0, 1'b0};
    tab[7]  = '{16369, 2'd3, 1'b1, 8'd255, 2'd0, 1'b0};
    tab[8]  = '{20000, 2'd1, 1'b0, 8'd0,   2'd0, 1'b0};
    tab[9]  = '{24560, 2'd1, 1'b0, 8'd0,   2'd0, 1'b0};
    tab[10] = '{24561, 2'd1, 1'b1, 8'd255, 2'd1, 1'b1};
    tab[11] = '{32752, 2'd1, 1'b0, 8'd0,   2'd1, 1'b1};
    tab[12] = '{32753, 2'd1, 1'b0, 8'd0,   2'd1, 1'b0};
    tab[13] = '{40945, 2'd1, 1'b1, 8'd128, 2'd1, 1'b0};
    tab[14] = '{40946, 2'd1, 1'b0, 8'd0,   2'd1, 1'b0};
    fork
      run_a();
      run_b();
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pdm_capture_scheduler.md
Name: pdm_capture_scheduler

Overview:
Sequences PDM capture from three on-board/PMOD microphones into one 8-bit sample stream at ~12 kHz.
- Generates the 3.072 MHz mic clock from clk_in (98.3 MHz).
- Selects one mic at a time and decimates 256 PDM bits per sample.
- Schedules mic switching so it happens only at window boundaries, followed by a settle period.
- Sits between the mic pins and the volume/PWM playback path in top_level.

Parameters:
- PDM_COUNT_PERIOD, 32, clk_in cycles per mic clock period (even, >=4).
- NUM_PDM_SAMPLES, 256, PDM bits per decimation window (power of 2).
- SETTLE_WINDOWS, 1, windows discarded after reset, enable, or mic switch (>=1).

Ports:
- clk_in, input, 1, 98.3 MHz audio clock.
- rst_in, input, 1, asynchronous active-high reset.
- enable_in, input, 1, capture enable.
- mic_sel_in, input, 2, requested mic: 0, 1 or 2; value 3 is ignored.
- mic_data_in, input, 3, PDM data, one bit per mic.
- mic_clk_out, output, 1, shared mic clock.
- sample_out, output, 8, unsigned decimated sample (ones tally, saturated).
- sample_valid_out, output, 1, single-cycle sample strobe.
- active_mic_out, output, 2, mic currently being tallied.
- settling_out, output, 1, high while in SETTLE.

Behaviour:
- Reset values: all outputs 0; state SETTLE; settle count = SETTLE_WINDOWS; active mic 0; pending-switch flag clear; divider, bit count and tally all 0.
- Divider counter:
  - Runs 0..PDM_COUNT_PERIOD-1 and wraps, while enable_in=1.
  - Registered mic_clk_out = 1 when counter >= PDM_COUNT_PERIOD/2.
  - pdm_step is high for one cycle when the counter equals PDM_COUNT_PERIOD/2 (first cycle mic_clk_out reads 1).
  - Cycle numbering: cycle n is the n-th edge after reset release, counter = n mod 32; pdm_step cycles are n = 16 + 32k.
- Tallying:
  - On pdm_step, mic_data_in[active mic] is added to a 9-bit tally and the bit count increments.
  - The step that makes bit count = NUM_PDM_SAMPLES is the window end.
- Window end:
  - sample_out <= min(tally, 255); tally and bit count clear.
  - In RUN, sample_valid_out = 1 in the following cycle (first window ends at cycle 8176, strobe at 8177). Strobes are 8192 cycles apart.
  - In SETTLE, no strobe; settle count decrements, and at 0 the state moves to RUN.
- Switch scheduling:
  - Each cycle, if mic_sel_in is not 3 and differs from the active mic, pending <= mic_sel_in and the pending flag is set.
  - If mic_sel_in is 3, or equals the active mic, the pending flag clears.
  - At window end with the flag set:
    - The window just finished still follows the RUN/SETTLE rule above (an old-mic sample may be emitted).
    - active mic <= pending; flag clears; state <= SETTLE; settle count reloads.
  - A request that first appears in the window-end cycle is applied at the next boundary.
- enable_in = 0:
  - Divider, bit count and tally are held at 0; mic_clk_out = 0; no strobes.
  - state <= SETTLE with settle count reloaded.
  - When enable returns high, timing restarts as if from reset, but the active mic is kept.
- Reset mid-window: state clears immediately and asynchronously; a partial window never produces a strobe.
- sample_out holds its value between strobes.

Decomposition:
- Package audio_pkg holds:
  - PDM_COUNT_PERIOD and NUM_PDM_SAMPLES defaults;
  - typedef mic_id_t (logic [1:0]) and MIC_NONE = 3;
  - enum cap_state_t {SETTLE, RUN}.
- Sub-module pdm_clk_gen (divider, mic_clk_out, pdm_step), reusable by future capture blocks.

Test Plan:
- Reset release, enable=1, mic 0 data constant 1 -> mic_clk_out toggles every 16 cycles; no strobe at cycle 8177; first strobe at cycle 16369 with sample_out=255 (tally 256 saturated); settling_out falls at cycle 8177.
- Mic 0 alternating 1/0 per step, mic 1 constant 0 -> every strobe 128; strobes exactly 8192 cycles apart.
- In RUN, mic_sel_in 0->1 at cycle 20000 -> strobe at 24561 still from mic 0; active_mic_out=1 from 24561; no strobe at 32753; next strobe at 40945 reflects mic 1.
- mic_sel_in=3 held -> active mic unchanged, no settle.
- Request 0->2 then back to 0 within one window -> no switch, no settle.
- Assert rst_in at cycle 12000 (mid-window) -> all outputs 0 immediately; timing restarts, first strobe 16369 cycles after release.
- enable_in low for 1000 cycles mid-window -> mic_clk_out held low; partial tally discarded; after re-enable, one SETTLE window precedes the next strobe; active mic preserved.
